// File: rtl/scr1_dmem_vec_responder.sv
// Scalar/vector DMEM responder: one request outstanding, fixed-latency RDY_OK/RDY_ER response,
// word array split into LANE banks. Define SCR1_DMEM_RANDOM_STALL_EN for LFSR-driven request stalls.
`ifndef LANE
`define LANE 4
`endif
`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif

package scr1_dmem_vec_responder_pkg;
  typedef enum logic [1:0] {
    SCR1_MEM_CMD_RD = 2'b00,
    SCR1_MEM_CMD_WR = 2'b01
  } type_scr1_mem_cmd_e;

  typedef enum logic [2:0] {
    SCR1_MEM_WIDTH_BYTE   = 3'd0,
    SCR1_MEM_WIDTH_HWORD  = 3'd1,
    SCR1_MEM_WIDTH_WORD   = 3'd2,
    SCR1_MEM_WIDTH_VECTOR = 3'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef logic [`LANE-1:0][31:0] type_vector;
endpackage

module scr1_dmem_vec_responder
  import scr1_dmem_vec_responder_pkg::*;
#(
  parameter int unsigned                  LANE         = `LANE,
  parameter int unsigned                  DEPTH_WORDS  = 4096,
  parameter logic [`SCR1_DMEM_AWIDTH-1:0] BASE_ADDR    = '0,
  parameter int unsigned                  RESP_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
  input  type_vector                    dmem_wdata,
  output logic                          dmem_req_ack,
  output type_vector                    dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp
);
  localparam int unsigned AW       = `SCR1_DMEM_AWIDTH;
  localparam int unsigned AWP1     = AW + 1;
  localparam int unsigned LOG_LANE = (LANE > 1) ? $clog2(LANE) : 0;
  localparam int unsigned SELW     = (LANE > 1) ? $clog2(LANE) : 1;
  localparam int unsigned ROWS     = DEPTH_WORDS / LANE;
  localparam int unsigned RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW:0]   SPAN   = AWP1'(DEPTH_WORDS) << 2;
  localparam logic [AW-1:0] VMASK  = AW'(LANE * 4 - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  type_scr1_mem_cmd_e   cmd_q, cmd_d;
  type_scr1_mem_width_e width_q, width_d;
  logic [1:0]           boff_q, boff_d;
  logic [SELW-1:0]      sel_q, sel_d;
  logic [RW-1:0]        row_q, row_d;
  logic                 err_q, err_d;
  type_vector           wdata_q, wdata_d;

  logic [AW:0]          diff;
  logic [AW-1:0]        offset;
  logic [RW-1:0]        req_row;
  logic [SELW-1:0]      req_sel;
  logic                 in_range, misalign, bad_enc, req_err;
  logic                 idle_ack, accept, commit;
  logic [LANE-1:0][3:0] bank_be;
  type_vector           bank_wd;
  type_vector           bank_rd;
  logic [31:0]          scalar_word;

`ifdef SCR1_DMEM_RANDOM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign idle_ack = ~lfsr_q[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign idle_ack = 1'b1;
`endif

  // Borrow out of the subtraction lands in diff[AW], so below-base addresses fail the span test.
  always_comb begin
    diff     = {1'b0, dmem_addr} - {1'b0, BASE_ADDR};
    offset   = diff[AW-1:0];
    in_range = (diff < SPAN);
    req_row  = offset[2+LOG_LANE +: RW];
    req_sel  = (LANE > 1) ? offset[2 +: SELW] : '0;
    bad_enc  = (dmem_cmd != SCR1_MEM_CMD_RD) && (dmem_cmd != SCR1_MEM_CMD_WR);
    misalign = 1'b0;
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:   misalign = 1'b0;
      SCR1_MEM_WIDTH_HWORD:  misalign = offset[0];
      SCR1_MEM_WIDTH_WORD:   misalign = |offset[1:0];
      SCR1_MEM_WIDTH_VECTOR: misalign = |(offset & VMASK);
      default:               bad_enc  = 1'b1;
    endcase
    req_err = ~in_range | misalign | bad_enc;
  end

  assign accept = (state_q == ST_IDLE) && dmem_req && idle_ack;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    width_d      = width_q;
    boff_d       = boff_q;
    sel_d        = sel_q;
    row_d        = row_q;
    err_d        = err_q;
    wdata_d      = wdata_q;
    dmem_req_ack = 1'b0;
    dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    commit       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dmem_req_ack = idle_ack;
        if (accept) begin
          cmd_d   = dmem_cmd;
          width_d = dmem_width;
          boff_d  = offset[1:0];
          sel_d   = req_sel;
          row_d   = req_row;
          err_d   = req_err;
          wdata_d = dmem_wdata;
          cnt_d   = 4'(RESP_LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          dmem_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
          commit    = ~err_q && (cmd_q == SCR1_MEM_CMD_WR);
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_BYTE;
      boff_q  <= '0;
      sel_q   <= '0;
      row_q   <= '0;
      err_q   <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      boff_q  <= boff_d;
      sel_q   <= sel_d;
      row_q   <= row_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
    end
  end

  // Scalar stores replicate the data across the word and let byte enables pick the lane.
  always_comb begin
    bank_be = '0;
    bank_wd = '0;
    for (int i = 0; i < LANE; i++) begin
      if (width_q == SCR1_MEM_WIDTH_VECTOR) begin
        bank_be[i] = 4'hF;
        bank_wd[i] = wdata_q[i];
      end else if (SELW'(i) == sel_q) begin
        case (width_q)
          SCR1_MEM_WIDTH_BYTE: begin
            bank_be[i] = 4'b0001 << boff_q;
            bank_wd[i] = {4{wdata_q[0][7:0]}};
          end
          SCR1_MEM_WIDTH_HWORD: begin
            bank_be[i] = boff_q[1] ? 4'b1100 : 4'b0011;
            bank_wd[i] = {2{wdata_q[0][15:0]}};
          end
          SCR1_MEM_WIDTH_WORD: begin
            bank_be[i] = 4'hF;
            bank_wd[i] = wdata_q[0];
          end
          default: bank_be[i] = 4'h0;
        endcase
      end
    end
    if (!commit) bank_be = '0;
  end

  // Bank i holds words whose index mod LANE == i; reads launch at accept so data is ready by the response.
  for (genvar gi = 0; gi < LANE; gi++) begin : g_bank
    logic [31:0] mem [ROWS];
    logic [31:0] rd_q;
    always_ff @(posedge clk) begin
      if (accept) rd_q <= mem[req_row];
      for (int b = 0; b < 4; b++) begin
        if (bank_be[gi][b]) mem[row_q][b*8 +: 8] <= bank_wd[gi][b*8 +: 8];
      end
    end
    assign bank_rd[gi] = rd_q;
  end

  assign scalar_word = bank_rd[sel_q];

  always_comb begin
    dmem_rdata = '0;
    if (dmem_resp == SCR1_MEM_RESP_RDY_OK && cmd_q == SCR1_MEM_CMD_RD) begin
      case (width_q)
        SCR1_MEM_WIDTH_BYTE:   dmem_rdata[0] = {24'h0, scalar_word[{boff_q, 3'b000} +: 8]};
        SCR1_MEM_WIDTH_HWORD:  dmem_rdata[0] = {16'h0, scalar_word[{boff_q[1], 4'b0000} +: 16]};
        SCR1_MEM_WIDTH_WORD:   dmem_rdata[0] = scalar_word;
        SCR1_MEM_WIDTH_VECTOR: dmem_rdata    = bank_rd;
        default:               dmem_rdata    = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_scr1_dmem_vec_responder.sv
// Directed bench for scr1_dmem_vec_responder: latency-1 instance for function, latency-3 instance
// for timing and mid-transaction reset.
module tb_scr1_dmem_vec_responder;
  import scr1_dmem_vec_responder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst1, rst3, req, sel3;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [31:0]          addr;
  type_vector           wdata;
  logic                 ack1, ack3, req1, req3, ack;
  type_vector           rdata1, rdata3, rdata;
  type_scr1_mem_resp_e  resp1, resp3, resp;

  assign req1  = req & ~sel3;
  assign req3  = req & sel3;
  assign ack   = sel3 ? ack3 : ack1;
  assign rdata = sel3 ? rdata3 : rdata1;
  assign resp  = sel3 ? resp3 : resp1;

  scr1_dmem_vec_responder #(.RESP_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst1), .dmem_req(req1), .dmem_cmd(cmd), .dmem_width(width),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack1), .dmem_rdata(rdata1), .dmem_resp(resp1)
  );

  scr1_dmem_vec_responder #(.RESP_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .dmem_req(req3), .dmem_cmd(cmd), .dmem_width(width),
    .dmem_addr(addr), .dmem_wdata(wdata), .dmem_req_ack(ack3), .dmem_rdata(rdata3), .dmem_resp(resp3)
  );

`ifdef SCR1_DMEM_RANDOM_STALL_EN
  localparam logic EXP_RST_ACK = 1'b0;
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst1) begin
    if (rst1) lfsr_m <= 16'hACE1;
    else      lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
  end
`else
  localparam logic EXP_RST_ACK = 1'b1;
`endif

  int                  cmp_n = 0;
  int                  fail_n = 0;
  type_scr1_mem_resp_e r_resp;
  type_vector          r_rdata;
  int                  r_lat;
  logic                r_ack_busy;
  time                 r_acc_t;

  // Drives one request, waits for the accept, then for the response; returns at the response negedge.
  task automatic txn(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                     input logic [31:0] a, input type_vector d);
    int n;
    @(negedge clk);
    req = 1'b1; cmd = c; width = w; addr = a; wdata = d;
    n = 0;
    forever begin
`ifdef SCR1_DMEM_RANDOM_STALL_EN
      if (!sel3) begin
        cmp_n++;
        if (ack !== ~lfsr_m[0]) begin
          fail_n++;
          $display("FAIL stall_ack got=%b exp=%b", ack, ~lfsr_m[0]);
        end
      end
`endif
      if (ack === 1'b1 || n >= 64) break;
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      cmp_n++; fail_n++;
      $display("FAIL ack_timeout addr=%h got_ack=%b exp_ack=1", a, ack);
      req = 1'b0; r_resp = SCR1_MEM_RESP_NOTRDY; r_rdata = '0; r_lat = 0;
      return;
    end
    @(posedge clk);
    r_acc_t = $time;
    #1 req = 1'b0;
    r_lat = 0;
    do begin
      @(negedge clk);
      r_lat++;
      r_ack_busy = ack;
    end while (resp == SCR1_MEM_RESP_NOTRDY && r_lat < 40);
    r_resp  = resp;
    r_rdata = rdata;
    if (resp == SCR1_MEM_RESP_NOTRDY) begin
      cmp_n++; fail_n++;
      $display("FAIL resp_timeout addr=%h got=NOTRDY exp=response", a);
    end
    $display("txn dut=%0d cmd=%0d width=%0d addr=%h resp=%0d lat=%0d rdata=%h",
             sel3 ? 3 : 1, c, w, a, r_resp, r_lat, r_rdata);
  endtask

  task automatic test_reset;
    cmp_n++; if (ack1 !== EXP_RST_ACK) begin fail_n++; $display("FAIL rst_ack1 got=%b exp=%b", ack1, EXP_RST_ACK); end
    cmp_n++; if (ack3 !== EXP_RST_ACK) begin fail_n++; $display("FAIL rst_ack3 got=%b exp=%b", ack3, EXP_RST_ACK); end
    cmp_n++; if (resp1 !== SCR1_MEM_RESP_NOTRDY) begin fail_n++; $display("FAIL rst_resp got=%0d exp=0", resp1); end
    cmp_n++; if (rdata1 !== '0) begin fail_n++; $display("FAIL rst_rdata got=%h exp=0", rdata1); end
  endtask

  task automatic test_word;
    type_vector v;
    v = '0; v[0] = 32'hDEADBEEF;
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, v);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_OK) begin fail_n++; $display("FAIL sw10_resp got=%0d exp=1", r_resp); end
    cmp_n++; if (r_ack_busy !== 1'b0) begin fail_n++; $display("FAIL sw10_busy_ack got=%b exp=0", r_ack_busy); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_OK) begin fail_n++; $display("FAIL lw10_resp got=%0d exp=1", r_resp); end
    cmp_n++; if (r_lat !== 1) begin fail_n++; $display("FAIL lw10_latency got=%0d exp=1", r_lat); end
    cmp_n++; if (r_rdata !== v) begin fail_n++; $display("FAIL lw10_data got=%h exp=%h", r_rdata, v); end
  endtask

  task automatic test_byte;
    type_vector v, e;
    v = '0; v[0] = 32'h000000A5;
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h13, v);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_OK) begin fail_n++; $display("FAIL sb13_resp got=%0d exp=1", r_resp); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, '0);
    e = '0; e[0] = 32'hA5ADBEEF;
    cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL lw10_after_sb got=%h exp=%h", r_rdata, e); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h13, '0);
    e = '0; e[0] = 32'h000000A5;
    cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL lb13 got=%h exp=%h", r_rdata, e); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h10, '0);
    e = '0; e[0] = 32'h000000EF;
    cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL lb10 got=%h exp=%h", r_rdata, e); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, '0);
    e = '0; e[0] = 32'h0000A5AD;
    cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL lh12 got=%h exp=%h", r_rdata, e); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h11, '0);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL lh11_resp got=%0d exp=2", r_resp); end
    cmp_n++; if (r_rdata !== '0) begin fail_n++; $display("FAIL lh11_data got=%h exp=0", r_rdata); end
  endtask

  task automatic test_vector;
    type_vector v, bad, e;
    v = '0; v[0] = 32'd1; v[1] = 32'd2; v[2] = 32'd3; v[3] = 32'd4;
    bad = '0; bad[0] = 32'hBAD0; bad[1] = 32'hBAD1; bad[2] = 32'hBAD2; bad[3] = 32'hBAD3;
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h20, v);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_OK) begin fail_n++; $display("FAIL sv20_resp got=%0d exp=1", r_resp); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h20, '0);
    cmp_n++; if (r_rdata !== v) begin fail_n++; $display("FAIL lv20 got=%h exp=%h", r_rdata, v); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h28, '0);
    e = '0; e[0] = 32'd3;
    cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL lw28 got=%h exp=%h", r_rdata, e); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h24, '0);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL lv24_resp got=%0d exp=2", r_resp); end
    cmp_n++; if (r_rdata !== '0) begin fail_n++; $display("FAIL lv24_data got=%h exp=0", r_rdata); end
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_VECTOR, 32'h24, bad);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL sv24_resp got=%0d exp=2", r_resp); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_VECTOR, 32'h20, '0);
    cmp_n++; if (r_rdata !== v) begin fail_n++; $display("FAIL lv20_unchanged got=%h exp=%h", r_rdata, v); end
  endtask

  task automatic test_range_and_encoding;
    type_vector v, e;
    v = '0; v[0] = 32'h11223344;
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, v);
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4000, '0);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL lw_oor_resp got=%0d exp=2", r_resp); end
    v[0] = 32'hFFFF0000;
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h4000, v);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL sw_oor_resp got=%0d exp=2", r_resp); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, '0);
    e = '0; e[0] = 32'h11223344;
    cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL lw0_unchanged got=%h exp=%h", r_rdata, e); end
    txn(type_scr1_mem_cmd_e'(2'b10), SCR1_MEM_WIDTH_WORD, 32'h0, '0);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL bad_cmd_resp got=%0d exp=2", r_resp); end
    txn(SCR1_MEM_CMD_RD, type_scr1_mem_width_e'(3'd5), 32'h0, '0);
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_ER) begin fail_n++; $display("FAIL bad_width_resp got=%0d exp=2", r_resp); end
  endtask

  task automatic test_back_to_back;
    type_vector v, e;
    time t_prev;
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      v = '0; v[0] = 32'h11111111 * i;
      txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100 + 32'(4 * i), v);
`ifndef SCR1_DMEM_RANDOM_STALL_EN
      if (i > 0) begin
        cmp_n++;
        if (r_acc_t - t_prev !== 20) begin fail_n++; $display("FAIL b2b_spacing got=%0t exp=20", r_acc_t - t_prev); end
      end
`endif
      t_prev = r_acc_t;
    end
    for (int i = 0; i < 8; i++) begin
      txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100 + 32'(4 * i), '0);
      e = '0; e[0] = 32'h11111111 * i;
      cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL b2b_read%0d got=%h exp=%h", i, r_rdata, e); end
    end
  endtask

  task automatic test_latency3;
    type_vector v;
    sel3 = 1'b1;
    v = '0; v[0] = 32'h12345678;
    txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h40, v);
    cmp_n++; if (r_lat !== 3) begin fail_n++; $display("FAIL lat3_sw got=%0d exp=3", r_lat); end
    cmp_n++; if (r_resp !== SCR1_MEM_RESP_RDY_OK) begin fail_n++; $display("FAIL lat3_sw_resp got=%0d exp=1", r_resp); end
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, '0);
    cmp_n++; if (r_lat !== 3) begin fail_n++; $display("FAIL lat3_lw got=%0d exp=3", r_lat); end
    cmp_n++; if (r_rdata !== v) begin fail_n++; $display("FAIL lat3_lw_data got=%h exp=%h", r_rdata, v); end
    sel3 = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    type_vector v;
    int n;
    sel3 = 1'b1;
    v = '0; v[0] = 32'hCAFEF00D;
    @(negedge clk);
    req = 1'b1; cmd = SCR1_MEM_CMD_WR; width = SCR1_MEM_WIDTH_WORD; addr = 32'h40; wdata = v;
    n = 0;
    while (ack !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) begin cmp_n++; fail_n++; $display("FAIL rstbusy_ack_timeout got_ack=%b exp_ack=1", ack); end
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    cmp_n++; if (resp3 !== SCR1_MEM_RESP_NOTRDY) begin fail_n++; $display("FAIL rstbusy_early_resp got=%0d exp=0", resp3); end
    @(posedge clk);
    #1 rst3 = 1'b1;
    @(posedge clk);
    #1 rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_n++; if (resp3 !== SCR1_MEM_RESP_NOTRDY) begin fail_n++; $display("FAIL rstbusy_resp%0d got=%0d exp=0", i, resp3); end
`ifndef SCR1_DMEM_RANDOM_STALL_EN
      cmp_n++; if (ack3 !== 1'b1) begin fail_n++; $display("FAIL rstbusy_ack%0d got=%b exp=1", i, ack3); end
`endif
    end
    v[0] = 32'h12345678;
    txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, '0);
    cmp_n++; if (r_rdata !== v) begin fail_n++; $display("FAIL rstbusy_old_value got=%h exp=%h", r_rdata, v); end
    sel3 = 1'b0;
  endtask

`ifdef SCR1_DMEM_RANDOM_STALL_EN
  task automatic test_random_stall;
    type_vector v, e;
    for (int i = 0; i < 50; i++) begin
      v = '0; v[0] = 32'h1000 + 32'(i);
      txn(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200 + 32'(4 * (i % 8)), v);
      txn(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200 + 32'(4 * (i % 8)), '0);
      e = '0; e[0] = 32'h1000 + 32'(i);
      cmp_n++; if (r_rdata !== e) begin fail_n++; $display("FAIL stall_rw%0d got=%h exp=%h", i, r_rdata, e); end
    end
  endtask
`endif

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; req = 1'b0; sel3 = 1'b0;
    cmd = SCR1_MEM_CMD_RD; width = SCR1_MEM_WIDTH_WORD; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    test_reset;
    test_word;
    test_byte;
    test_vector;
    test_range_and_encoding;
    test_back_to_back;
    test_latency3;
    test_reset_mid_busy;
`ifdef SCR1_DMEM_RANDOM_STALL_EN
    test_random_stall;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
